// File: rtl/dataflow_sync_ctrl_if.sv
// Task and per-process handshake bundle between a dataflow sequencer and its environment.
// The slave side is the sequencer; the master side issues tasks and models the processes.
interface dataflow_sync_ctrl_if #(
  parameter int PROC_NUM = 2
);
  logic                ap_start;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_continue;
  logic                ap_idle;
  logic [PROC_NUM-1:0] proc_start;
  logic [PROC_NUM-1:0] proc_ready;
  logic [PROC_NUM-1:0] proc_done;
  logic [PROC_NUM-1:0] proc_continue;
  logic [PROC_NUM-1:0] done_reg;
  logic                stall_flag;
  logic [PROC_NUM-1:0] stall_vec;

  modport master (
    output ap_start, ap_continue, proc_ready, proc_done,
    input  ap_ready, ap_done, ap_idle, proc_start, proc_continue, done_reg,
           stall_flag, stall_vec
  );

  modport slave (
    input  ap_start, ap_continue, proc_ready, proc_done,
    output ap_ready, ap_done, ap_idle, proc_start, proc_continue, done_reg,
           stall_flag, stall_vec
  );
endinterface

// File: rtl/dataflow_sync_ctrl.sv
// Starts PROC_NUM dataflow processes per task, latches their dones and releases them together.
// A no-progress watchdog records which processes were still outstanding when it fired.
module dataflow_sync_ctrl #(
  parameter int PROC_NUM    = 2,
  parameter int STALL_LIMIT = 1000,
  parameter int CNT_W       = 32
) (
  input  logic                  dl_clock,
  input  logic                  dl_reset,
  dataflow_sync_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_ap_idle;
  logic                r_ap_done;
  logic [PROC_NUM-1:0] r_start_ack;
  logic [PROC_NUM-1:0] r_done_reg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_stall_flag;
  logic [PROC_NUM-1:0] r_stall_vec;

  logic                w_in_start;
  logic                w_in_run;
  logic [PROC_NUM-1:0] w_proc_start;
  logic [PROC_NUM-1:0] w_new_ack;
  logic [PROC_NUM-1:0] w_new_done;
  logic                w_all_acked;
  logic                w_all_done;
  logic                w_progress;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_stall_hit;

  assign w_in_start   = (r_state == S_START);
  assign w_in_run     = (r_state == S_RUN);
  assign w_proc_start = w_in_start ? ~r_start_ack : '0;
  assign w_new_ack    = w_proc_start & bus.proc_ready;
  assign w_all_acked  = w_in_start && (&(r_start_ack | w_new_ack));
  // A done arriving in the same cycle as the last outstanding one still completes the task.
  assign w_new_done   = w_in_run ? (bus.proc_done & ~r_done_reg) : '0;
  assign w_all_done   = w_in_run && (&(r_done_reg | bus.proc_done));
  assign w_progress   = (|w_new_ack) || (|w_new_done);

  always_comb begin
    w_cnt_nxt = '0;
    if ((w_in_start || w_in_run) && !w_progress) begin
      w_cnt_nxt = (r_cnt >= LIMIT) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  assign w_stall_hit = (w_cnt_nxt >= LIMIT) && (w_in_start || w_in_run) && !w_progress;

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_state     <= S_IDLE;
      r_ap_idle   <= 1'b1;
      r_ap_done   <= 1'b0;
      r_start_ack <= '0;
      r_done_reg  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            r_state   <= S_START;
            r_ap_idle <= 1'b0;
          end
        end
        S_START: begin
          if (w_all_acked) begin
            r_start_ack <= '0;
            r_state     <= S_RUN;
          end else begin
            r_start_ack <= r_start_ack | w_new_ack;
          end
        end
        S_RUN: begin
          if (w_all_done) begin
            r_done_reg <= '0;
            r_state    <= S_DONE;
            r_ap_done  <= 1'b1;
          end else begin
            r_done_reg <= r_done_reg | w_new_done;
          end
        end
        S_DONE: begin
          if (bus.ap_continue) begin
            r_ap_done <= 1'b0;
            if (bus.ap_start) begin
              r_state <= S_START;
            end else begin
              r_state   <= S_IDLE;
              r_ap_idle <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_ap_idle <= 1'b1;
          r_ap_done <= 1'b0;
        end
      endcase
    end
  end

  // The flag and its snapshot are captured once and only cleared by reset.
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_cnt        <= '0;
      r_stall_flag <= 1'b0;
      r_stall_vec  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_stall_hit && !r_stall_flag) begin
        r_stall_flag <= 1'b1;
        r_stall_vec  <= w_in_start ? ~r_start_ack : ~r_done_reg;
      end
    end
  end

  assign bus.ap_ready      = w_all_acked;
  assign bus.ap_done       = r_ap_done;
  assign bus.ap_idle       = r_ap_idle;
  assign bus.proc_start    = w_proc_start;
  assign bus.proc_continue = w_all_done ? '1 : '0;
  assign bus.done_reg      = r_done_reg;
  assign bus.stall_flag    = r_stall_flag;
  assign bus.stall_vec     = r_stall_vec;

endmodule

// File: tb/tb_dataflow_sync_ctrl.sv
// Directed bench for dataflow_sync_ctrl (2 processes, stall limit 8): a task-level model checked
// every cycle, plus literal expectations at the cycles the scenarios pin down.
module tb_dataflow_sync_ctrl;
  localparam int P   = 2;
  localparam int LIM = 8;
  localparam logic [1:0] ALL = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  dataflow_sync_ctrl_if #(.PROC_NUM(P)) bus ();

  dataflow_sync_ctrl #(.PROC_NUM(P), .STALL_LIMIT(LIM), .CNT_W(8)) dut (
    .dl_clock (clk),
    .dl_reset (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Task-level model: phase of the task, which processes have accepted / finished,
  // how long nothing has moved, and the sticky stall snapshot.
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WORK = 2, PH_FINISHED = 3;
  int         m_phase, n_phase;
  logic [1:0] m_acc, n_acc, m_fin, n_fin, m_vec, n_vec;
  int         m_quiet, n_quiet;
  logic       m_flag, n_flag;

  initial begin
    logic [1:0] e_ps, got_acc, fresh, e_pc;
    logic       e_rdy;
    m_phase = PH_IDLE; m_acc = 0; m_fin = 0; m_vec = 0; m_quiet = 0; m_flag = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = PH_IDLE; m_acc = 0; m_fin = 0; m_vec = 0; m_quiet = 0; m_flag = 0;
      end
      e_ps    = (m_phase == PH_LAUNCH) ? ~m_acc : 2'b00;
      got_acc = e_ps & bus.proc_ready;
      e_rdy   = (m_phase == PH_LAUNCH) && ((m_acc | got_acc) == ALL);
      fresh   = (m_phase == PH_WORK) ? (bus.proc_done & ~m_fin) : 2'b00;
      e_pc    = ((m_phase == PH_WORK) && ((m_fin | bus.proc_done) == ALL)) ? ALL : 2'b00;

      cmp("ap_ready",      8'(bus.ap_ready),      8'(e_rdy));
      cmp("ap_done",       8'(bus.ap_done),       8'(m_phase == PH_FINISHED));
      cmp("ap_idle",       8'(bus.ap_idle),       8'(m_phase == PH_IDLE));
      cmp("proc_start",    8'(bus.proc_start),    8'(e_ps));
      cmp("proc_continue", 8'(bus.proc_continue), 8'(e_pc));
      cmp("done_reg",      8'(bus.done_reg),      8'(m_fin));
      cmp("stall_flag",    8'(bus.stall_flag),    8'(m_flag));
      cmp("stall_vec",     8'(bus.stall_vec),     8'(m_vec));

      n_phase = m_phase; n_acc = m_acc; n_fin = m_fin;
      n_quiet = m_quiet; n_flag = m_flag; n_vec = m_vec;
      if (m_phase == PH_IDLE && bus.ap_start) n_phase = PH_LAUNCH;
      if (m_phase == PH_LAUNCH) begin
        n_acc = e_rdy ? 2'b00 : (m_acc | got_acc);
        if (e_rdy) n_phase = PH_WORK;
      end
      if (m_phase == PH_WORK) begin
        n_fin = (e_pc == ALL) ? 2'b00 : (m_fin | fresh);
        if (e_pc == ALL) n_phase = PH_FINISHED;
      end
      if (m_phase == PH_FINISHED && bus.ap_continue)
        n_phase = bus.ap_start ? PH_LAUNCH : PH_IDLE;
      if ((m_phase == PH_LAUNCH || m_phase == PH_WORK) && (got_acc | fresh) == 2'b00) begin
        n_quiet = (m_quiet + 1 > LIM) ? LIM : m_quiet + 1;
        if (n_quiet >= LIM && !m_flag) begin
          n_flag = 1'b1;
          n_vec  = (m_phase == PH_LAUNCH) ? ~m_acc : ~m_fin;
        end
      end else begin
        n_quiet = 0;
      end

      @(posedge clk);
      if (rst_n) begin
        m_phase = n_phase; m_acc = n_acc; m_fin = n_fin;
        m_quiet = n_quiet; m_flag = n_flag; m_vec = n_vec;
      end else begin
        m_phase = PH_IDLE; m_acc = 0; m_fin = 0; m_vec = 0; m_quiet = 0; m_flag = 0;
      end
    end
  end

  // One cycle of stimulus: inputs change just after the edge, returns mid-cycle for checks.
  task automatic drv(input logic s, input logic c, input logic [1:0] r, input logic [1:0] d);
    @(posedge clk);
    #1;
    bus.ap_start    = s;
    bus.ap_continue = c;
    bus.proc_ready  = r;
    bus.proc_done   = d;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.ap_start = 0; bus.ap_continue = 0; bus.proc_ready = 0; bus.proc_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_ap_idle", 8'(bus.ap_idle), 8'd1);
    cmp("rst_ap_done", 8'(bus.ap_done), 8'd0);
    cmp("rst_proc_start", 8'(bus.proc_start), 8'd0);
    cmp("rst_stall_flag", 8'(bus.stall_flag), 8'd0);
    #2 rst_n = 1'b1;

    // Scenario 1: basic task, dones in different cycles
    drv(1, 0, 2'b00, 2'b00); cmp("s1_c0_idle", 8'(bus.ap_idle), 8'd1);
    drv(1, 0, 2'b11, 2'b00); cmp("s1_c1_ready", 8'(bus.ap_ready), 8'd1);
                             cmp("s1_c1_pstart", 8'(bus.proc_start), 8'd3);
    drv(0, 0, 2'b00, 2'b00); cmp("s1_c2_ready", 8'(bus.ap_ready), 8'd0);
    drv(0, 0, 2'b00, 2'b00);
    drv(0, 0, 2'b00, 2'b01); cmp("s1_c4_dreg", 8'(bus.done_reg), 8'd0);
    drv(0, 0, 2'b00, 2'b01); cmp("s1_c5_dreg", 8'(bus.done_reg), 8'd1);
                             cmp("s1_c5_pcont", 8'(bus.proc_continue), 8'd0);
    drv(0, 0, 2'b00, 2'b01);
    drv(0, 0, 2'b00, 2'b11); cmp("s1_c7_pcont", 8'(bus.proc_continue), 8'd3);
                             cmp("s1_c7_done", 8'(bus.ap_done), 8'd0);
    drv(0, 1, 2'b00, 2'b00); cmp("s1_c8_done", 8'(bus.ap_done), 8'd1);
                             cmp("s1_c8_pcont", 8'(bus.proc_continue), 8'd0);
    drv(0, 0, 2'b00, 2'b00); cmp("s1_c9_idle", 8'(bus.ap_idle), 8'd1);

    // Scenario 2: staggered start acceptance; scenario 3: simultaneous dones
    drv(1, 0, 2'b00, 2'b00);
    drv(1, 0, 2'b01, 2'b00); cmp("s2_c1_pstart", 8'(bus.proc_start), 8'd3);
                             cmp("s2_c1_ready", 8'(bus.ap_ready), 8'd0);
    drv(1, 0, 2'b00, 2'b00); cmp("s2_c2_pstart", 8'(bus.proc_start), 8'd2);
    drv(1, 0, 2'b10, 2'b00); cmp("s2_c3_pstart", 8'(bus.proc_start), 8'd2);
                             cmp("s2_c3_ready", 8'(bus.ap_ready), 8'd1);
    drv(0, 0, 2'b00, 2'b00); cmp("s2_c4_pstart", 8'(bus.proc_start), 8'd0);
    drv(0, 0, 2'b00, 2'b11); cmp("s3_pcont", 8'(bus.proc_continue), 8'd3);
                             cmp("s3_dreg", 8'(bus.done_reg), 8'd0);
    drv(0, 1, 2'b00, 2'b00); cmp("s3_done", 8'(bus.ap_done), 8'd1);
    drv(0, 0, 2'b00, 2'b00);

    // Scenario 4: process 1 never reports until after the watchdog fires
    drv(1, 0, 2'b00, 2'b00);
    drv(1, 0, 2'b11, 2'b00);
    drv(0, 0, 2'b00, 2'b00);
    drv(0, 0, 2'b00, 2'b01);
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 2'b00, 2'b01);
      cmp($sformatf("s4_quiet%0d_flag", k), 8'(bus.stall_flag), 8'd0);
    end
    drv(0, 0, 2'b00, 2'b01); cmp("s4_flag", 8'(bus.stall_flag), 8'd1);
                             cmp("s4_vec", 8'(bus.stall_vec), 8'd2);
    drv(0, 0, 2'b00, 2'b11); cmp("s4_pcont", 8'(bus.proc_continue), 8'd3);
    drv(0, 1, 2'b00, 2'b00); cmp("s4_done", 8'(bus.ap_done), 8'd1);
    drv(0, 0, 2'b00, 2'b00); cmp("s4_sticky", 8'(bus.stall_flag), 8'd1);
                             cmp("s4_idle", 8'(bus.ap_idle), 8'd1);

    // Scenario 5: reset in the middle of RUN
    drv(1, 0, 2'b00, 2'b00);
    drv(1, 0, 2'b11, 2'b00);
    drv(0, 0, 2'b00, 2'b00);
    drv(0, 0, 2'b00, 2'b01);
    drv(0, 0, 2'b00, 2'b01); cmp("s5_dreg_pre", 8'(bus.done_reg), 8'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.proc_done = 2'b00;
    #1;
    cmp("s5_dreg", 8'(bus.done_reg), 8'd0);
    cmp("s5_idle", 8'(bus.ap_idle), 8'd1);
    cmp("s5_flag", 8'(bus.stall_flag), 8'd0);
    cmp("s5_vec", 8'(bus.stall_vec), 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drv(1, 0, 2'b00, 2'b00);
    drv(1, 0, 2'b11, 2'b00); cmp("s5_ready", 8'(bus.ap_ready), 8'd1);
    drv(0, 0, 2'b00, 2'b00);
    drv(0, 0, 2'b00, 2'b11); cmp("s5_pcont", 8'(bus.proc_continue), 8'd3);

    // Scenario 6: consumer holds off, then restarts straight from DONE
    drv(0, 0, 2'b00, 2'b00); cmp("s6_done0", 8'(bus.ap_done), 8'd1);
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 2'b00, 2'b00);
      cmp($sformatf("s6_hold%0d", k), 8'(bus.ap_done), 8'd1);
    end
    drv(1, 1, 2'b00, 2'b00); cmp("s6_cont_done", 8'(bus.ap_done), 8'd1);
    drv(1, 0, 2'b00, 2'b00); cmp("s6_start_idle", 8'(bus.ap_idle), 8'd0);
                             cmp("s6_start_pstart", 8'(bus.proc_start), 8'd3);
                             cmp("s6_start_done", 8'(bus.ap_done), 8'd0);
    drv(1, 0, 2'b11, 2'b00); cmp("s6_ready", 8'(bus.ap_ready), 8'd1);
    drv(0, 0, 2'b00, 2'b11); cmp("s6_pcont", 8'(bus.proc_continue), 8'd3);
    drv(0, 1, 2'b00, 2'b00); cmp("s6_done", 8'(bus.ap_done), 8'd1);
    drv(0, 0, 2'b00, 2'b00); cmp("s6_idle", 8'(bus.ap_idle), 8'd1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
